// File: rtl/useq_pkg.sv
// Shared constants for the microprogram next-address control stage:
// opcode encodings, sequencer source selects, stack depth and the
// microword pipeline layout.
package useq_pkg;

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CONT = 4'd1;
  localparam logic [3:0] OP_CJP  = 4'd2;
  localparam logic [3:0] OP_CJS  = 4'd3;
  localparam logic [3:0] OP_CRTN = 4'd4;
  localparam logic [3:0] OP_LDCT = 4'd5;
  localparam logic [3:0] OP_RPCT = 4'd6;
  localparam logic [3:0] OP_LOOP = 4'd7;
  localparam logic [3:0] OP_PUSH = 4'd8;
  localparam logic [3:0] OP_LDAR = 4'd9;
  localparam logic [3:0] OP_JAR  = 4'd10;
  localparam logic [3:0] OP_WAIT = 4'd11;

  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  localparam logic [2:0] STACK_DEPTH = 3'd4;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] csel;
    logic       cpol;
    logic [7:0] cnt;
  } uword_t;

  typedef enum logic [1:0] {
    CNT_KEEP = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_act_t;

  // Select 0 is a constant-true condition; selects 1..7 pick flags[sel-1].
  function automatic logic sel_cond(input logic [2:0] csel, input logic cpol,
                                    input logic [6:0] flags);
    logic [7:0] ext;
    ext = {flags, 1'b1};
    return ext[csel] ^ cpol;
  endfunction

endpackage

// File: rtl/useq_decode.sv
// Combinational decode: registered opcode, live condition and counter
// state -> sequencer slice controls and counter action. Stall overrides.
module useq_decode
  import useq_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       cond_i,
  input  logic       cnt_nz_i,
  input  logic       hold_i,
  output logic [1:0] src_o,
  output logic       fe_n_o,
  output logic       pup_o,
  output logic       re_n_o,
  output logic       zero_n_o,
  output logic       cin_o,
  output cnt_act_t   cnt_act_o
);

  // Opcode decode with defaults first; a stall freezes the address (cin=0).
  always_comb begin
    src_o     = SRC_PC;
    fe_n_o    = 1'b1;
    pup_o     = 1'b0;
    re_n_o    = 1'b1;
    zero_n_o  = 1'b1;
    cin_o     = 1'b1;
    cnt_act_o = CNT_KEEP;
    if (hold_i) begin
      cin_o = 1'b0;
    end else begin
      case (op_i)
        OP_JZ:   zero_n_o = 1'b0;
        OP_CONT: ;
        OP_CJP:  if (cond_i) src_o = SRC_D;
        OP_CJS:  if (cond_i) begin
                   src_o  = SRC_D;
                   fe_n_o = 1'b0;
                   pup_o  = 1'b1;
                 end
        OP_CRTN: if (cond_i) begin
                   src_o  = SRC_STK;
                   fe_n_o = 1'b0;
                 end
        OP_LDCT: cnt_act_o = CNT_LOAD;
        OP_RPCT: if (cnt_nz_i) begin
                   src_o     = SRC_D;
                   cnt_act_o = CNT_DEC;
                 end
        OP_LOOP: if (!cond_i) src_o = SRC_STK;
                 else         fe_n_o = 1'b0;
        OP_PUSH: begin
                   fe_n_o = 1'b0;
                   pup_o  = 1'b1;
                   if (cond_i) cnt_act_o = CNT_LOAD;
                 end
        OP_LDAR: re_n_o = 1'b0;
        OP_JAR:  src_o = SRC_AR;
        OP_WAIT: if (!cond_i) cin_o = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microprogram next-address control stage: microword pipeline register,
// 8-bit loop counter and sequencer control outputs.
// Optional stack-depth monitor enabled by defining USEQ_STACK_CHECK_EN.
module useq_ctrl
  import useq_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       hold,
  input  logic [3:0] u_op,
  input  logic [2:0] u_csel,
  input  logic       u_cpol,
  input  logic [7:0] u_cnt,
  input  logic [6:0] flags,
  output logic       s1,
  output logic       s0,
  output logic       fe_n,
  output logic       pup,
  output logic       re_n,
  output logic       zero_n,
  output logic       cin,
  output logic       cnt_zero,
  output logic       stack_err
);

  uword_t     word_q, word_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cond;
  logic [1:0] src;
  cnt_act_t   cnt_act;

  assign cond = sel_cond(word_q.csel, word_q.cpol, flags);

  useq_decode u_decode (
    .op_i      (word_q.op),
    .cond_i    (cond),
    .cnt_nz_i  (cnt_q != 8'd0),
    .hold_i    (hold),
    .src_o     (src),
    .fe_n_o    (fe_n),
    .pup_o     (pup),
    .re_n_o    (re_n),
    .zero_n_o  (zero_n),
    .cin_o     (cin),
    .cnt_act_o (cnt_act)
  );

  assign {s1, s0} = src;
  assign cnt_zero = (cnt_q == 8'd0);

  // Next microword and counter value; the decode already suppresses
  // counter actions during a stall, and RPCT never decrements past 0.
  always_comb begin
    word_d = hold ? word_q : '{op: u_op, csel: u_csel, cpol: u_cpol, cnt: u_cnt};
    cnt_d  = cnt_q;
    case (cnt_act)
      CNT_LOAD: cnt_d = word_q.cnt;
      CNT_DEC:  cnt_d = cnt_q - 8'd1;
      default:  cnt_d = cnt_q;
    endcase
  end

  // Pipeline register and loop counter; reset leaves a JZ in the pipe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word_q <= '{op: OP_JZ, csel: 3'd0, cpol: 1'b0, cnt: 8'd0};
      cnt_q  <= 8'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef USEQ_STACK_CHECK_EN
  logic [2:0] depth_q, depth_d;
  logic       err_q, err_d;

  // Track issued pushes/pops (fe_n is already high while stalled);
  // depth saturates and any overflow/underflow latches the error.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (!fe_n) begin
      if (pup) begin
        if (depth_q == STACK_DEPTH) err_d = 1'b1;
        else                        depth_d = depth_q + 3'd1;
      end else begin
        if (depth_q == 3'd0) err_d = 1'b1;
        else                 depth_d = depth_q - 3'd1;
      end
    end
  end

  // Depth and sticky error registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      depth_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_useq_ctrl.sv
// Scoreboard bench for useq_ctrl: directed test-plan sequences followed by
// randomized microwords, compared against a behavioural model.
module tb_useq_ctrl;

  logic       clock = 1'b0;
  logic       reset_n, hold, u_cpol;
  logic [3:0] u_op;
  logic [2:0] u_csel;
  logic [7:0] u_cnt;
  logic [6:0] flags;
  logic       s1, s0, fe_n, pup, re_n, zero_n, cin, cnt_zero, stack_err;

  always #5 clock = ~clock;

  useq_ctrl dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .u_op(u_op),
    .u_csel(u_csel), .u_cpol(u_cpol), .u_cnt(u_cnt), .flags(flags),
    .s1(s1), .s0(s0), .fe_n(fe_n), .pup(pup), .re_n(re_n),
    .zero_n(zero_n), .cin(cin), .cnt_zero(cnt_zero), .stack_err(stack_err)
  );

  typedef struct {
    logic [8:0] val;
    logic [8:0] mask;
    string      tag;
  } exp_t;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string cur_tag = "init";

  // Model state: microword in effect, loop count, stack depth, error.
  int m_op = 0, m_csel = 0, m_cpol = 0, m_cnt = 0;
  int m_ctr = 0, m_depth = 0;
  bit m_err = 0, m_known = 0;

  // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
  task automatic step(input bit rst, input bit hld, input int op, input int csel,
                      input int cpol, input int cnt, input logic [6:0] flg);
    bit   c, fe, pu, re, zn, ci;
    int   s;
    exp_t e;
    @(posedge clock);
    #1;
    reset_n = ~rst;
    hold    = hld;
    u_op    = op[3:0];
    u_csel  = csel[2:0];
    u_cpol  = cpol[0];
    u_cnt   = cnt[7:0];
    flags   = flg;

    c  = ((m_csel == 0) ? 1'b1 : flg[m_csel-1]) ^ m_cpol[0];
    s  = 0; fe = 1; pu = 0; re = 1; zn = 1; ci = 1;
    if (hld) ci = 0;
    else begin
      case (m_op)
        0:  zn = 0;
        2:  if (c) s = 3;
        3:  if (c) begin s = 3; fe = 0; pu = 1; end
        4:  if (c) begin s = 2; fe = 0; end
        6:  if (m_ctr != 0) s = 3;
        7:  if (!c) s = 2; else fe = 0;
        8:  begin fe = 0; pu = 1; end
        9:  re = 0;
        10: s = 1;
        11: if (!c) ci = 0;
        default: ;
      endcase
    end

    if (m_known) begin
      e.val[8:7] = s[1:0];
      e.val[6]   = fe;
      e.val[5]   = pu;
      e.val[4]   = re;
      e.val[3]   = zn;
      e.val[2]   = ci;
      e.val[1]   = (m_ctr == 0);
`ifdef USEQ_STACK_CHECK_EN
      e.val[0]   = m_err;
`else
      e.val[0]   = 1'b0;
`endif
      e.mask = hld ? 9'b111011111 : 9'b111111111;
      e.tag  = cur_tag;
      sb.push_back(e);
    end

    if (rst) begin
      m_op = 0; m_csel = 0; m_cpol = 0; m_cnt = 0;
      m_ctr = 0; m_depth = 0; m_err = 0; m_known = 1;
    end else if (!hld) begin
      if (m_op == 5) m_ctr = m_cnt;
      else if (m_op == 6 && m_ctr > 0) m_ctr = m_ctr - 1;
      else if (m_op == 8 && c) m_ctr = m_cnt;
      if (!fe) begin
        if (pu) begin
          if (m_depth == 4) m_err = 1; else m_depth = m_depth + 1;
        end else begin
          if (m_depth == 0) m_err = 1; else m_depth = m_depth - 1;
        end
      end
      m_op = op; m_csel = csel; m_cpol = cpol; m_cnt = cnt;
    end
  endtask

  // Monitor: compare every predicted cycle on the falling edge.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {s1, s0, fe_n, pup, re_n, zero_n, cin, cnt_zero, stack_err};
        n_chk++;
        if ((act & e.mask) === (e.val & e.mask)) n_pass++;
        else $display("FAIL %s: got {s1,s0,fe_n,pup,re_n,zero_n,cin,cnt_zero,stack_err}=%b required %b (mask %b) at %0t",
                      e.tag, act, e.val, e.mask, $time);
      end
    end
  end

  initial begin
    int op, csel, cnt;
    reset_n = 1'b0; hold = 1'b0; u_op = 4'd0; u_csel = 3'd0;
    u_cpol = 1'b0; u_cnt = 8'd0; flags = 7'd0;

    cur_tag = "reset";
    step(1, 0, 1, 0, 0, 0, 7'd0);
    step(1, 0, 1, 0, 0, 0, 7'd0);
    cur_tag = "after_reset";
    step(0, 0, 1, 0, 0, 0, 7'd0);
    step(0, 0, 1, 0, 0, 0, 7'd0);

    cur_tag = "cjs";
    step(0, 0, 3, 2, 0, 0, 7'b0000010);
    step(0, 0, 3, 2, 0, 0, 7'b0000010);
    step(0, 0, 1, 0, 0, 0, 7'b0000000);
    step(0, 0, 1, 0, 0, 0, 7'b0000000);

    cur_tag = "rpct";
    step(0, 0, 5, 0, 0, 3, 7'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 6, 0, 0, 0, 7'd0);
    step(0, 0, 1, 0, 0, 0, 7'd0);
    step(0, 0, 1, 0, 0, 0, 7'd0);

    cur_tag = "wait";
    step(0, 0, 5, 0, 0, 7, 7'd0);
    step(0, 0, 11, 1, 0, 0, 7'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 11, 1, 0, 0, 7'd0);
    step(0, 1, 1, 0, 0, 0, 7'd0);
    step(0, 1, 6, 0, 0, 0, 7'd0);
    step(0, 0, 11, 1, 0, 0, 7'b0000001);
    step(0, 0, 1, 0, 0, 0, 7'b0000001);
    step(0, 0, 1, 0, 0, 0, 7'd0);

    cur_tag = "stack";
    step(1, 0, 1, 0, 0, 0, 7'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 8, 0, 0, 9, 7'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 7'd0);
    step(1, 0, 1, 0, 0, 0, 7'd0);
    step(0, 0, 1, 0, 0, 0, 7'd0);
    step(0, 0, 1, 0, 0, 0, 7'd0);

    cur_tag = "random";
    for (int i = 0; i < 1500; i++) begin
      op   = $urandom_range(0, 15);
      csel = $urandom_range(0, 7);
      cnt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           op, csel, $urandom_range(0, 1), cnt, 7'($urandom));
    end

    @(negedge clock);
    @(negedge clock);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d predictions left required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
